// File: rtl/load_unit_pkg.sv
// load_unit_pkg: load/store size codes and load sequencer state encodings.
// Optional sign extension is enabled by defining LOAD_SIGN_EXT_EN.
// The store path decodes size with the same 2-bit codes.
package load_unit_pkg;

  // Shared load/store size field
  typedef logic [1:0] ls_size_t;

  localparam ls_size_t LS_WORD = 2'b00;
  localparam ls_size_t LS_HALF = 2'b01;
  localparam ls_size_t LS_BYTE = 2'b10;
  localparam ls_size_t LS_RSVD = 2'b11;

  // Sequencer states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Latency down-counter width; covers MEM_LATENCY up to 15
  localparam int CNT_W = 4;

endpackage

// File: rtl/load_unit_if.sv
// load_unit_if: request, memory read and result signals of the load sequencer.
// ls_signed exists only when LOAD_SIGN_EXT_EN is defined.
// slave = load unit side, master = datapath/memory side.
interface load_unit_if
  import load_unit_pkg::*;
#(
  parameter int ADDR_W = 32
);
  logic              start;
  ls_size_t          ls_ctrl;
  logic [ADDR_W-1:0] addr;
`ifdef LOAD_SIGN_EXT_EN
  logic              ls_signed;
`endif
  logic              ready;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic [31:0]       data_out;
  logic              done;

  modport slave (
`ifdef LOAD_SIGN_EXT_EN
    input  ls_signed,
`endif
    input  start, ls_ctrl, addr, mem_data,
    output ready, mem_rd, mem_addr, data_out, done
  );

  modport master (
`ifdef LOAD_SIGN_EXT_EN
    output ls_signed,
`endif
    output start, ls_ctrl, addr, mem_data,
    input  ready, mem_rd, mem_addr, data_out, done
  );
endinterface

// File: rtl/load_extract.sv
// load_extract: selects word/half/byte from a read word, zero- or sign-extended.
// Latency: combinational. Backpressure: none.
// Sign select port exists only with LOAD_SIGN_EXT_EN; reserved code yields zero.
module load_extract
  import load_unit_pkg::*;
(
  input  logic [31:0] i_word,
  input  ls_size_t    i_size,
`ifdef LOAD_SIGN_EXT_EN
  input  logic        i_signed,
`endif
  output logic [31:0] o_data
);

  // Size select; low bits taken as-is, no lane shifting by address
  always_comb begin
    o_data = 32'h0;
    case (i_size)
      LS_WORD: o_data = i_word;
      LS_HALF: begin
        o_data = {16'h0, i_word[15:0]};
`ifdef LOAD_SIGN_EXT_EN
        if (i_signed) o_data = {{16{i_word[15]}}, i_word[15:0]};
`endif
      end
      LS_BYTE: begin
        o_data = {24'h0, i_word[7:0]};
`ifdef LOAD_SIGN_EXT_EN
        if (i_signed) o_data = {{24{i_word[7]}}, i_word[7:0]};
`endif
      end
      default: o_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// load_unit: multi-cycle load sequencer (IDLE->REQ->WAIT->DONE), LOAD_SIGN_EXT_EN adds signed loads.
// Latency: done pulses 2+MEM_LATENCY cycles after start is accepted; one load per 3+MEM_LATENCY cycles.
// Backpressure: ready is high only in IDLE; start while busy is dropped, never queued.
module load_unit
  import load_unit_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 32
)(
  input  logic      clk,
  input  logic      reset,
  load_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  ls_size_t          r_size;
`ifdef LOAD_SIGN_EXT_EN
  logic              r_sgn;
`endif
  logic              r_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_data;
  logic              r_done;
  logic [31:0]       w_ext;

  // Extraction runs on the live memory word; only captured on the last WAIT cycle
  load_extract u_extract (
    .i_word   (bus.mem_data),
    .i_size   (r_size),
`ifdef LOAD_SIGN_EXT_EN
    .i_signed (r_sgn),
`endif
    .o_data   (w_ext)
  );

  // Sequencer: latch request, strobe read, count latency, capture and pulse done
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_size     <= LS_WORD;
`ifdef LOAD_SIGN_EXT_EN
      r_sgn      <= 1'b0;
`endif
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_data     <= 32'h0;
      r_done     <= 1'b0;
    end else begin
      r_mem_rd <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_size     <= bus.ls_ctrl;
`ifdef LOAD_SIGN_EXT_EN
            r_sgn      <= bus.ls_signed;
`endif
            // mem_addr doubles as the latched address and holds through WAIT
            r_mem_addr <= bus.addr;
            r_mem_rd   <= 1'b1;
            r_state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          r_cnt   <= CNT_LOAD;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_data  <= w_ext;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready    = (r_state == ST_IDLE);
  assign bus.mem_rd   = r_mem_rd;
  assign bus.mem_addr = r_mem_addr;
  assign bus.data_out = r_data;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: two load units (MEM_LATENCY 1 and 3) against a cycle-age model,
// plus directed loads with hand-computed results. Sign tests need LOAD_SIGN_EXT_EN.
module tb_load_unit;
  import load_unit_pkg::*;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst;
  logic [1:0]  x_start;
  logic [1:0]  x_sgn;
  logic [1:0]  x_ctrl  [2];
  logic [31:0] x_addr  [2];
  logic [31:0] x_mdata [2];

  logic        o_ready  [2];
  logic        o_mem_rd [2];
  logic        o_done   [2];
  logic [31:0] o_addr   [2];
  logic [31:0] o_data   [2];

  int n_checks = 0;
  int n_errors = 0;

  load_unit_if #(.ADDR_W(32)) bus0 ();
  load_unit_if #(.ADDR_W(32)) bus1 ();

  load_unit #(.MEM_LATENCY(LAT0), .ADDR_W(32)) u_dut0 (.clk(clk), .reset(rst[0]), .bus(bus0));
  load_unit #(.MEM_LATENCY(LAT1), .ADDR_W(32)) u_dut1 (.clk(clk), .reset(rst[1]), .bus(bus1));

  assign bus0.start    = x_start[0];
  assign bus0.ls_ctrl  = x_ctrl[0];
  assign bus0.addr     = x_addr[0];
  assign bus0.mem_data = x_mdata[0];
  assign bus1.start    = x_start[1];
  assign bus1.ls_ctrl  = x_ctrl[1];
  assign bus1.addr     = x_addr[1];
  assign bus1.mem_data = x_mdata[1];
`ifdef LOAD_SIGN_EXT_EN
  assign bus0.ls_signed = x_sgn[0];
  assign bus1.ls_signed = x_sgn[1];
`endif

  assign o_ready[0]  = bus0.ready;
  assign o_mem_rd[0] = bus0.mem_rd;
  assign o_done[0]   = bus0.done;
  assign o_addr[0]   = bus0.mem_addr;
  assign o_data[0]   = bus0.data_out;
  assign o_ready[1]  = bus1.ready;
  assign o_mem_rd[1] = bus1.mem_rd;
  assign o_done[1]   = bus1.done;
  assign o_addr[1]   = bus1.mem_addr;
  assign o_data[1]   = bus1.data_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  // Reference extraction using plain arithmetic on the word value
  function automatic logic [31:0] ref_extract(input logic [31:0] w, input logic [1:0] code,
                                              input logic sgn);
    logic [31:0] r;
    case (code)
      2'd0: r = w;
      2'd1: begin
        r = w % 32'h10000;
        if (sgn && r >= 32'h8000) r = r - 32'h10000;
      end
      2'd2: begin
        r = w % 32'h100;
        if (sgn && r >= 32'h80) r = r - 32'h100;
      end
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Model: age = cycles since acceptance (0 = idle); REQ at age 1, last WAIT at 1+L, DONE at 2+L
  int          age    [2];
  bit          armed  [2];
  logic [31:0] m_data [2];
  logic [31:0] m_addr [2];
  logic [1:0]  m_code [2];
  logic        m_sgn  [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      age[d] = 0; armed[d] = 1'b0; m_data[d] = 0; m_addr[d] = 0; m_code[d] = 0; m_sgn[d] = 0;
    end
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst[d]) begin
          age[d] = 0; m_data[d] = 32'h0; m_addr[d] = 32'h0; armed[d] = 1'b1;
        end else if (armed[d]) begin
          if (age[d] == 0) begin
            if (x_start[d]) begin
              age[d]    = 1;
              m_addr[d] = x_addr[d];
              m_code[d] = x_ctrl[d];
`ifdef LOAD_SIGN_EXT_EN
              m_sgn[d]  = x_sgn[d];
`else
              m_sgn[d]  = 1'b0;
`endif
            end
          end else begin
            if (age[d] == 1 + lat_of(d))
              m_data[d] = ref_extract(x_mdata[d], m_code[d], m_sgn[d]);
            age[d] = (age[d] == 2 + lat_of(d)) ? 0 : age[d] + 1;
          end
        end
      end
    end
  end

  // Compare every output of both units against the model on the falling edge
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (armed[d]) begin
        chk($sformatf("dut%0d ready", d),    32'(o_ready[d]),  32'(age[d] == 0));
        chk($sformatf("dut%0d mem_rd", d),   32'(o_mem_rd[d]), 32'(age[d] == 1));
        chk($sformatf("dut%0d done", d),     32'(o_done[d]),   32'(age[d] == 2 + lat_of(d)));
        chk($sformatf("dut%0d mem_addr", d), o_addr[d],        m_addr[d]);
        chk($sformatf("dut%0d data_out", d), o_data[d],        m_data[d]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle, then scramble the request fields
  task automatic issue(input int d, input logic [1:0] c, input logic [31:0] a, input logic s);
    x_start[d] = 1'b1; x_ctrl[d] = c; x_addr[d] = a; x_sgn[d] = s;
    tick();
    x_start[d] = 1'b0; x_ctrl[d] = ~c; x_addr[d] = ~a; x_sgn[d] = ~s;
  endtask

  // One complete load; mem_data is garbage except in the last WAIT cycle
  task automatic run_load(input int d, input logic [1:0] c, input logic [31:0] a, input logic s,
                          input logic [31:0] word, input bit pulse,
                          output int done_cyc, output logic [31:0] res, output int n_done);
    int l;
    l = lat_of(d);
    done_cyc = -1; res = 32'hX; n_done = 0;
    issue(d, c, a, s);
    for (int cyc = 1; cyc <= l + 5; cyc++) begin
      x_mdata[d] = (cyc == 1 + l) ? word : $urandom;
      x_start[d] = (pulse && cyc == 2) ? 1'b1 : 1'b0;
      if (cyc == 1) begin
        chk($sformatf("dut%0d mem_rd in REQ", d), 32'(o_mem_rd[d]), 32'd1);
        chk($sformatf("dut%0d mem_addr in REQ", d), o_addr[d], a);
      end
      if (cyc == 3 + l) chk($sformatf("dut%0d ready after done", d), 32'(o_ready[d]), 32'd1);
      if (o_done[d]) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = cyc; res = o_data[d];
        end
      end
      tick();
    end
    x_start[d] = 1'b0;
  endtask

  task automatic load_expect(input string name, input int d, input logic [1:0] c,
                             input logic [31:0] a, input logic s, input logic [31:0] word,
                             input bit pulse, input logic [31:0] exp);
    int dc, nd;
    logic [31:0] r;
    run_load(d, c, a, s, word, pulse, dc, r, nd);
    chk({name, " done cycle"}, 32'(dc), 32'(2 + lat_of(d)));
    chk({name, " result"}, r, exp);
    chk({name, " done count"}, 32'(nd), 32'd1);
  endtask

  initial begin
    int nd;
    rst = 2'b11;
    x_start = 2'b00; x_sgn = 2'b00;
    for (int d = 0; d < 2; d++) begin
      x_ctrl[d] = 2'b00; x_addr[d] = 32'h0; x_mdata[d] = 32'h0;
    end
    tick();
    x_start = 2'b11;  // reset must override start
    tick();
    x_start = 2'b00;
    for (int d = 0; d < 2; d++) begin
      chk("reset ready",    32'(o_ready[d]),  32'd1);
      chk("reset mem_rd",   32'(o_mem_rd[d]), 32'd0);
      chk("reset done",     32'(o_done[d]),   32'd0);
      chk("reset mem_addr", o_addr[d],        32'h0);
      chk("reset data_out", o_data[d],        32'h0);
    end
    rst = 2'b00;

    load_expect("word L1",  0, LS_WORD, 32'h40,   1'b0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF);
    load_expect("half L1",  0, LS_HALF, 32'h1002, 1'b0, 32'h1234_8A7F, 1'b0, 32'h0000_8A7F);
    load_expect("byte L1",  0, LS_BYTE, 32'h1003, 1'b0, 32'h1234_8A7F, 1'b0, 32'h0000_007F);
    load_expect("rsvd L1",  0, LS_RSVD, 32'h1004, 1'b0, 32'h1234_8A7F, 1'b0, 32'h0000_0000);
    load_expect("byte80 u", 0, LS_BYTE, 32'h2000, 1'b0, 32'h0000_0080, 1'b0, 32'h0000_0080);
`ifdef LOAD_SIGN_EXT_EN
    load_expect("half s",   0, LS_HALF, 32'h3000, 1'b1, 32'h1234_8A7F, 1'b0, 32'hFFFF_8A7F);
    load_expect("byte s",   0, LS_BYTE, 32'h3001, 1'b1, 32'h1234_8A7F, 1'b0, 32'h0000_007F);
    load_expect("byte80 s", 0, LS_BYTE, 32'h3002, 1'b1, 32'h0000_0080, 1'b0, 32'hFFFF_FF80);
    load_expect("word s",   0, LS_WORD, 32'h3003, 1'b1, 32'h8000_0001, 1'b0, 32'h8000_0001);
    load_expect("rsvd s",   0, LS_RSVD, 32'h3004, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000);
    load_expect("half u",   0, LS_HALF, 32'h3005, 1'b0, 32'h1234_8A7F, 1'b0, 32'h0000_8A7F);
`endif

    load_expect("word L3",  1, LS_WORD, 32'h80,   1'b0, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D);
    load_expect("half L3",  1, LS_HALF, 32'h84,   1'b0, 32'h1234_8A7F, 1'b0, 32'h0000_8A7F);

    // Reset during WAIT aborts with no done pulse
    issue(1, LS_WORD, 32'h90, 1'b0);
    x_mdata[1] = 32'h1111_2222;
    tick();
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    chk("abort done",     32'(o_done[1]),   32'd0);
    chk("abort data_out", o_data[1],        32'h0);
    chk("abort mem_rd",   32'(o_mem_rd[1]), 32'd0);
    chk("abort ready",    32'(o_ready[1]),  32'd1);
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      if (o_done[1]) nd++;
      tick();
    end
    chk("abort done count", 32'(nd), 32'd0);

    load_expect("byte after abort", 1, LS_BYTE, 32'hA0, 1'b0, 32'h0000_0155, 1'b0, 32'h0000_0055);

    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
